// File: rtl/sound_gen.sv
// sound_gen: square-wave audio generator driven by a memory-mapped half-period
// register. Writing a non-zero half-period P starts a tone of period 2*P clk
// cycles; writing 0 silences it. Writes made while a tone is playing are held
// pending and take effect only at the next half-cycle boundary, so the
// waveform never glitches or shortens a half-cycle.
//
// Optional feature: define SOUND_MUTE_EN to make bit wordsize-1 of each write
// a mute flag that gates audPWM/audEn immediately while the tone keeps
// running in the background.
module sound_gen #(
    parameter int wordsize = 32,
    parameter int PERIOD_W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sound_wr,
    input  logic [wordsize-1:0] cpu_writedata,
    output logic                audPWM,
    output logic                audEn
);

    typedef enum logic {
        SILENT = 1'b0,
        TONE   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] p_q, p_d;
    logic [PERIOD_W-1:0] n_q, n_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                pwm_q, pwm_d;
    logic [PERIOD_W-1:0] wr_val;
    logic [PERIOD_W-1:0] next_p;
    logic                boundary;
    logic                unused_upper;

    assign wr_val       = cpu_writedata[PERIOD_W-1:0];
    assign unused_upper = ^cpu_writedata[wordsize-1:PERIOD_W];
    assign boundary     = (state_q == TONE) && (cnt_q == (p_q - PERIOD_W'(1)));

    // State and datapath registers; reset wins over any same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SILENT;
            p_q     <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            pwm_q   <= pwm_d;
        end
    end

    // Next-state logic: immediate load when silent, deferred update when
    // playing. A write coinciding with a boundary bypasses the pending slot.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        pwm_d   = pwm_q;
        next_p  = p_q;
        case (state_q)
            SILENT: begin
                if (sound_wr) begin
                    p_d     = wr_val;
                    cnt_d   = '0;
                    pwm_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = (wr_val != '0) ? TONE : SILENT;
                end
            end
            TONE: begin
                if (boundary) begin
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    if (sound_wr) begin
                        next_p = wr_val;
                    end else if (valid_q) begin
                        next_p = n_q;
                    end
                    p_d = next_p;
                    if (next_p == '0) begin
                        pwm_d   = 1'b0;
                        state_d = SILENT;
                    end else begin
                        pwm_d = ~pwm_q;
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                    if (sound_wr) begin
                        n_d     = wr_val;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = SILENT;
        endcase
    end

`ifdef SOUND_MUTE_EN
    logic mute_q;

    // Mute flag follows the top data bit of every write, independent of boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            mute_q <= 1'b0;
        end else if (sound_wr) begin
            mute_q <= cpu_writedata[wordsize-1];
        end
    end

    assign audPWM = pwm_q & ~mute_q;
    assign audEn  = (state_q == TONE) & ~mute_q;
`else
    assign audPWM = pwm_q;
    assign audEn  = (state_q == TONE);
`endif

endmodule

// File: tb/tb_sound_gen.sv
// Testbench for sound_gen: fixed vectors, hand sequences for the deferred
// update corner cases, and randomized traffic against an elapsed-time model.
module tb_sound_gen;
    localparam int WS = 32;
    localparam int PW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sound_wr = 1'b0;
    logic [WS-1:0] cpu_writedata = '0;
    logic          audPWM;
    logic          audEn;

    always #5 clk = ~clk;

    sound_gen #(.wordsize(WS), .PERIOD_W(PW)) dut (
        .clk(clk),
        .reset(reset),
        .sound_wr(sound_wr),
        .cpu_writedata(cpu_writedata),
        .audPWM(audPWM),
        .audEn(audEn)
    );

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;
    int     tog[$];
    logic   prev_pwm = 1'b0;

    // Reference model: tone period, pending value, time the current half began.
    int     m_p = 0;
    int     m_pend = -1;
    int     m_out = 0;
    int     m_mute = 0;
    longint m_start = 0;

    typedef struct {
        logic          rst;
        logic          wr;
        logic [WS-1:0] data;
        logic          pwm;
        logic          en;
    } vec_t;
    vec_t tbl[$];

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%b expected=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic w, input logic [WS-1:0] d);
        int v;
        int nv;
        v = int'(d[PW-1:0]);
        if (r) begin
            m_p = 0; m_pend = -1; m_out = 0; m_mute = 0;
        end else begin
            if (m_p == 0) begin
                if (w) begin
                    m_p = v; m_out = 0; m_start = cyc + 1;
                end
            end else if (cyc - m_start == longint'(m_p - 1)) begin
                nv = w ? v : ((m_pend >= 0) ? m_pend : m_p);
                m_pend = -1;
                m_start = cyc + 1;
                if (nv == 0) begin
                    m_p = 0; m_out = 0;
                end else begin
                    m_p = nv; m_out = 1 - m_out;
                end
            end else if (w) begin
                m_pend = v;
            end
`ifdef SOUND_MUTE_EN
            if (w) m_mute = int'(d[WS-1]);
`endif
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [WS-1:0] d);
        reset = r; sound_wr = w; cpu_writedata = d;
        @(posedge clk);
        model_edge(r, w, d);
        cyc++;
        #1;
        check_bit("model_pwm", audPWM, (m_out != 0) && (m_mute == 0));
        check_bit("model_en", audEn, (m_p != 0) && (m_mute == 0));
        if (audPWM !== prev_pwm) tog.push_back(int'(cyc));
        prev_pwm = audPWM;
        reset = 1'b0; sound_wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    task automatic check_gaps(input string name, input int g0, input int g1, input int g2);
        check_int({name, "_toggles"}, (tog.size() >= 4) ? 1 : 0, 1);
        if (tog.size() >= 4) begin
            check_int({name, "_gap0"}, tog[1] - tog[0], g0);
            check_int({name, "_gap1"}, tog[2] - tog[1], g1);
            check_int({name, "_gap2"}, tog[3] - tog[2], g2);
        end
    endtask

    initial begin
        // Startup, first tone timing, P==1, coincident zero write, upper bits ignored.
        tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h4, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1});
        for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
        for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h1, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h7FF0_0003, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h0, 1'b1, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].wr, tbl[i].data);
            check_bit($sformatf("vec%0d_pwm", i), audPWM, tbl[i].pwm);
            check_bit($sformatf("vec%0d_en", i), audEn, tbl[i].en);
        end

        // Retune mid half-cycle: current half stays 4, then halves of 8.
        step(1'b1, 1'b0, '0); tog.delete();
        step(1'b0, 1'b1, 32'd4);
        idle(6);
        step(1'b0, 1'b1, 32'd8);
        idle(18);
        check_gaps("retune", 4, 8, 8);

        // Zero written mid half-cycle silences only at the boundary.
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'd4);
        idle(5);
        step(1'b0, 1'b1, 32'd0);
        idle(1);
        check_bit("stop_before_boundary_en", audEn, 1'b1);
        idle(1);
        check_bit("stop_at_boundary_en", audEn, 1'b0);
        check_bit("stop_at_boundary_pwm", audPWM, 1'b0);
        idle(6);
        check_bit("stop_stays_silent", audEn, 1'b0);

        // Last pending write wins; write on the boundary applies immediately.
        step(1'b1, 1'b0, '0); tog.delete();
        step(1'b0, 1'b1, 32'd4);
        step(1'b0, 1'b1, 32'd6);
        step(1'b0, 1'b1, 32'd10);
        idle(11);
        step(1'b0, 1'b1, 32'd5);
        idle(12);
        check_gaps("lastwins_bypass", 10, 5, 5);

        // Reset together with a write during a tone discards the write.
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'd4);
        idle(2);
        step(1'b0, 1'b1, 32'd6);
        step(1'b1, 1'b1, 32'd7);
        check_bit("rst_wr_en", audEn, 1'b0);
        check_bit("rst_wr_pwm", audPWM, 1'b0);
        idle(14);
        check_bit("rst_wr_later_en", audEn, 1'b0);
        check_bit("rst_wr_later_pwm", audPWM, 1'b0);

`ifdef SOUND_MUTE_EN
        // Muted tone keeps running; unmuting resumes mid-waveform.
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 32'h8000_0004);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check_bit("mute_en", audEn, 1'b0);
            check_bit("mute_pwm", audPWM, 1'b0);
        end
        step(1'b0, 1'b1, 32'h0000_0004);
        check_bit("unmute_en", audEn, 1'b1);
        check_bit("unmute_pwm", audPWM, 1'b1);
        idle(1);
        check_bit("unmute_pwm_hold", audPWM, 1'b1);
        idle(1);
        check_bit("unmute_pwm_toggle", audPWM, 1'b0);
`endif

        // Randomized traffic against the model.
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 3000; i++) begin
            logic          r;
            logic          w;
            logic [WS-1:0] d;
            r = ($urandom_range(0, 149) == 0);
            w = ($urandom_range(0, 3) == 0);
            d = ($urandom() & 32'hFFF0_0000) | 32'($urandom_range(0, 9));
            step(r, w, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sound_gen.md
SOUND_GEN -- requirements
Module: sound_gen

Interface
REQ-001 SHALL have parameter wordsize, default 32, meaning the CPU data bus width.
REQ-002 SHALL have parameter PERIOD_W, default 20, meaning the half-period counter width (1..wordsize-1).
REQ-003 SHALL have port clk  input  1  system clock; every register updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sound_wr  input  1  one-cycle write strobe from the memory map (sound register slot).
REQ-006 SHALL have port cpu_writedata  input  wordsize  write data; bits [PERIOD_W-1:0] are the half-period in clk cycles.
REQ-007 SHALL have port audPWM  output  1  square-wave audio output.
REQ-008 SHALL have port audEn  output  1  audio amplifier enable.

Function
REQ-009 SHALL hold an active half-period register P, a pending register N with a valid flag, a counter cnt and the output bit, all PERIOD_W or 1 bit wide.
REQ-010 SHALL operate in two states: SILENT (P==0) and TONE (P!=0).
REQ-011 In SILENT, sound_wr with value V SHALL load P=V, cnt=0, audPWM=0 on the next edge; state becomes TONE if V!=0.
REQ-012 In TONE, cnt SHALL increment by 1 each cycle; when cnt==P-1 (boundary) cnt SHALL return to 0.
REQ-013 At a boundary with no pending value, audPWM SHALL toggle; so the output period is 2*P clk cycles.
REQ-014 In TONE, sound_wr SHALL capture V into N and set valid; P SHALL be unchanged until the next boundary (no glitch or truncated half-cycle).
REQ-015 At a boundary with valid set, P SHALL take N, valid SHALL clear and audPWM SHALL toggle; if N==0, audPWM SHALL instead go 0 and state SHALL become SILENT.
REQ-016 sound_wr in the same cycle as a boundary SHALL apply V at that boundary, bypassing N, and valid SHALL clear.
REQ-017 A second sound_wr before the boundary SHALL overwrite N; last write wins.
REQ-018 Bits [wordsize-1:PERIOD_W] of cpu_writedata SHALL be ignored, except as defined in REQ-024.
REQ-019 P==1 SHALL toggle audPWM every cycle, giving a period of 2 cycles.
REQ-020 audEn SHALL be 1 exactly when the state is TONE (subject to REQ-024).

Reset
REQ-021 While reset is high, P, N, valid, cnt and audPWM SHALL be cleared and audEn SHALL be 0 on the next edge.
REQ-022 Reset SHALL take priority over sound_wr in the same cycle; the write SHALL be discarded.
REQ-023 Reset during TONE or with a pending value SHALL return the block to SILENT with no pending value.

Configuration
REQ-024 With macro SOUND_MUTE_EN defined, bit wordsize-1 of each write SHALL set a mute flag one cycle after sound_wr, in any state, without waiting for a boundary; the flag resets to 0.
REQ-025 While muted, audPWM and audEn SHALL be 0 and cnt, P and N SHALL keep running; unmuting SHALL resume mid-waveform.
REQ-026 With SOUND_MUTE_EN undefined, no mute flag SHALL exist and bit wordsize-1 SHALL be ignored like the other upper bits.

Verification
REQ-027 Reset, then write 4 at cycle 0 -> audEn=1 from cycle 1; audPWM rises at cycle 5, falls at 9, rises at 13.
REQ-028 P=4 running, write 8 two cycles after a toggle -> current half-cycle still lasts 4 cycles, then half-cycles are 8 cycles.
REQ-029 P=4 running, write 0 mid half-cycle -> at the next boundary audPWM=0, audEn=0, cnt stays 0.
REQ-030 P=4, writes of 6 then 10 before the boundary -> 10 is applied; write coincident with the boundary -> applied at that same boundary.
REQ-031 Assert reset together with sound_wr during TONE -> next cycle all outputs 0 and a later boundary applies nothing.
REQ-032 With SOUND_MUTE_EN: write 0x80000004 -> audEn and audPWM stay 0 while cnt cycles; then write 0x00000004 -> audPWM resumes in phase with the counter.
